// File: rtl/line_stream_feeder.sv
// line_stream_feeder: replays a stored image as a pixel stream, with prefill,
// per-request lines and trailing zero padding lines.
module line_stream_feeder #(
   parameter int PIX_W         = 8,
   parameter int IMG_W         = 512,
   parameter int IMG_H         = 360,
   parameter int PREFILL_LINES = 4,
   parameter int PAD_LINES     = 2,
   parameter int REQ_W         = 3,
   parameter int ADDR_W        = $clog2(IMG_W*IMG_H)
) (
   input  logic              axi_clk,
   input  logic              axi_reset_n,
   input  logic              i_start,
   input  logic              i_line_req,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [PIX_W-1:0]  i_rd_data,
   output logic              o_data_valid,
   output logic [PIX_W-1:0]  o_data,
   output logic              o_busy,
   output logic              o_done
);
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = $clog2(IMG_H+1);
   localparam int PW = (PAD_LINES > 0) ? $clog2(PAD_LINES+1) : 1;

   typedef enum logic [2:0] {IDLE, PREFILL, WAIT_REQ, LINE, PAD, DONE} state_t;
   state_t state, state_nx;

   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [PW-1:0]    pad;
   logic [REQ_W-1:0] pend;
   logic             req_q, rd_q, pad_q;
   logic [PIX_W-1:0] hold;
   logic             col_last, req_edge, inc, dec;

   assign col_last     = col == CW'(IMG_W-1);
   assign req_edge     = i_line_req & ~req_q;
   assign inc          = req_edge && !(&pend);
   assign dec          = state == WAIT_REQ && |pend;
   assign o_rd_en      = state == PREFILL || state == LINE;
   assign o_busy       = state != IDLE;
   assign o_data_valid = rd_q | pad_q;
   // memory data arrives one cycle after the read strobe; pad beats ride the same delay
   assign o_data       = rd_q ? i_rd_data : pad_q ? '0 : hold;

   always_ff @(posedge axi_clk or negedge axi_reset_n)
      if (!axi_reset_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (i_start) state_nx = PREFILL;
         PREFILL:  if (col_last && row == RW'(PREFILL_LINES-1)) state_nx = WAIT_REQ;
         WAIT_REQ: if (|pend) state_nx = (row == RW'(IMG_H)) ? PAD : LINE;
         LINE:     if (col_last) state_nx = WAIT_REQ;
         PAD:      if (col_last) state_nx = (pad == PW'(PAD_LINES-1)) ? DONE : WAIT_REQ;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n)
      if (!axi_reset_n) begin
         col       <= '0;
         row       <= '0;
         pad       <= '0;
         pend      <= '0;
         o_rd_addr <= '0;
         req_q     <= 1'b0;
         rd_q      <= 1'b0;
         pad_q     <= 1'b0;
         o_done    <= 1'b0;
         hold      <= '0;
      end else begin
         req_q  <= i_line_req;
         rd_q   <= o_rd_en;
         pad_q  <= state == PAD;
         o_done <= state == DONE;
         hold   <= o_data;
         if (state == IDLE) begin
            col       <= '0;
            row       <= '0;
            pad       <= '0;
            pend      <= '0;
            o_rd_addr <= '0;
         end else if (state == DONE) begin
            pend <= '0;
         end else begin
            pend <= (inc && !dec) ? pend + 1'b1 : (dec && !inc) ? pend - 1'b1 : pend;
            if (o_rd_en) o_rd_addr <= o_rd_addr + 1'b1;
            if (o_rd_en || state == PAD) col <= col_last ? '0 : col + 1'b1;
            if (o_rd_en && col_last) row <= row + 1'b1;
            if (state == PAD && col_last) pad <= pad + 1'b1;
         end
      end
endmodule

// File: tb/tb_line_stream_feeder.sv
// tb_line_stream_feeder: directed checks of prefill, requested lines,
// request saturation, padding/done, start-while-busy and mid-line reset.
module tb_line_stream_feeder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       req = 1'b0;
   logic       rd_en;
   logic [5:0] rd_addr;
   logic [7:0] rd_data = 8'h00;
   logic       valid;
   logic [7:0] data;
   logic       busy, done;
   int         total = 0, bad = 0, vcnt = 0, v0;

   line_stream_feeder #(.PIX_W(8), .IMG_W(8), .IMG_H(6), .PREFILL_LINES(4),
                        .PAD_LINES(2), .REQ_W(2)) dut (
      .axi_clk(clk), .axi_reset_n(rst_n), .i_start(start), .i_line_req(req),
      .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
      .o_data_valid(valid), .o_data(data), .o_busy(busy), .o_done(done));

   always #5 clk = ~clk;

   // image memory: value = address
   always @(posedge clk) if (rd_en) rd_data <= {2'b00, rd_addr};
   always @(posedge clk) if (valid) vcnt <= vcnt + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beats(input string tag, input int base, input int n, input bit zero);
      for (int i = 0; i < n; i++) begin
         step();
         chk(tag, {valid, data}, {1'b1, zero ? 8'd0 : 8'(base + i)});
         if (zero) chk({tag, " rd_en"}, rd_en, 0);
      end
   endtask

   task automatic idle(input string tag, input int n, input int hold);
      for (int i = 0; i < n; i++) begin
         step();
         chk(tag, {valid, data}, {1'b0, 8'(hold)});
      end
   endtask

   task automatic pulse(input string tag, input bit padl, input int addr);
      req = 1'b1;
      step();
      chk({tag, " pend"}, dut.pend, 1);
      chk({tag, " wait"}, rd_en, 0);
      req = 1'b0;
      step();
      chk({tag, " rd"}, {rd_en, padl ? 6'd0 : 6'(addr)}, {!padl, padl ? 6'd0 : 6'(addr)});
   endtask

   task automatic run_start();
      v0 = vcnt;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start", {busy, rd_en, rd_addr, valid}, {1'b1, 1'b1, 6'd0, 1'b0});
   endtask

   task automatic finish_check(input string tag);
      chk({tag, " last"}, done, 0);
      step();
      chk({tag, " done"}, {done, busy, valid}, 3'b100);
      step();
      chk({tag, " done1"}, done, 0);
      chk({tag, " count"}, vcnt - v0, 64);
   endtask

   initial begin
      #1;
      chk("reset", {rd_en, rd_addr, valid, data, busy, done}, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("idle", {busy, rd_en, valid}, 0);

      run_start();
      beats("A prefill", 0, 32, 0);
      idle("A idle", 10, 31);
      pulse("A l4", 0, 32);
      beats("A l4 data", 32, 8, 0);
      idle("A gap", 3, 39);
      pulse("A l5", 0, 40);
      start = 1'b1;
      beats("A l5 data", 40, 1, 0);
      start = 1'b0;
      beats("A l5 data", 41, 7, 0);
      chk("A busy", busy, 1);
      idle("A gap2", 2, 47);
      pulse("A p0", 1, 0);
      beats("A pad0", 0, 8, 1);
      idle("A gap3", 3, 0);
      pulse("A p1", 1, 0);
      beats("A pad1", 0, 8, 1);
      finish_check("A");

      run_start();
      for (int i = 0; i < 5; i++) begin
         req = 1'b1;
         step();
         req = 1'b0;
         step();
      end
      chk("B sat", dut.pend, 3);
      for (int i = 0; i < 22; i++) step();
      chk("B prefill end", {valid, data}, {1'b1, 8'd31});
      idle("B gap0", 1, 31);
      beats("B l4", 32, 8, 0);
      idle("B gap1", 1, 39);
      beats("B l5", 40, 8, 0);
      idle("B gap2", 1, 47);
      beats("B pad0", 0, 8, 1);
      idle("B wait", 20, 0);
      pulse("B p1", 1, 0);
      beats("B pad1", 0, 8, 1);
      finish_check("B");

      run_start();
      beats("C prefill", 0, 32, 0);
      pulse("C l4", 0, 32);
      beats("C l4 data", 32, 8, 0);
      pulse("C l5", 0, 40);
      beats("C l5 data", 40, 3, 0);
      rst_n = 1'b0;
      #1;
      chk("C abort", {rd_en, rd_addr, valid, data, busy, done}, 0);
      idle("C held", 2, 0);
      rst_n = 1'b1;
      step();
      run_start();
      beats("C replay", 0, 8, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/line_stream_feeder.md
# line_stream_feeder

Parametrised, synthesizable pixel-stream source that replays a stored grayscale image into the line-buffered convolution/max-pool pipeline. It turns the simulation-only stimulus flow into hardware: prefill N lines, then send one line per downstream interrupt, then append zero padding lines. It sits between an image memory (BRAM read port) and the pipeline slave interface (`i_data_valid`/`i_data`), with the pipeline's `o_intr` fed back as the line request.

## Interface
- `PIX_W`, 8: pixel width in bits.
- `IMG_W`, 512: pixels per line.
- `IMG_H`, 360: lines per image; `PREFILL_LINES` ≤ `IMG_H`.
- `PREFILL_LINES`, 4: lines sent back-to-back after start, without requests.
- `PAD_LINES`, 2: zero lines appended after the image, one per request.
- `REQ_W`, 3: pending-request counter width.
- `ADDR_W`, $clog2(IMG_W*IMG_H): memory address width.

Ports:
- `axi_clk` in 1: sole clock, rising edge.
- `axi_reset_n` in 1: asynchronous active-low reset.
- `i_start` in 1: one-cycle start pulse; ignored unless idle.
- `i_line_req` in 1: downstream interrupt; rising edge = one line request.
- `o_rd_en` out 1: memory read strobe.
- `o_rd_addr` out ADDR_W: linear address, row*IMG_W+col.
- `i_rd_data` in PIX_W: memory data, valid exactly 1 cycle after `o_rd_en`.
- `o_data_valid` out 1: pixel valid to pipeline.
- `o_data` out PIX_W: pixel to pipeline.
- `o_busy` out 1: high from the cycle after accepted start until done.
- `o_done` out 1: one-cycle pulse after last pad beat.

## Operation
- States: IDLE, PREFILL, WAIT_REQ, LINE, PAD, DONE.
- IDLE: `i_start`=1 → PREFILL; clear line/column/address counters and pending counter.
- PREFILL: one `o_rd_en` per cycle, address increments by 1, `PREFILL_LINES*IMG_W` reads contiguous, no gaps; then WAIT_REQ (or PAD-wait if `PREFILL_LINES`=`IMG_H`).
- Request detect: register `i_line_req`; edge = now & !prev. Edge increments pending (saturates at 2^REQ_W-1, extra edges dropped). Edges counted in every non-IDLE state, including during PREFILL and LINE.
- WAIT_REQ with pending>0: decrement pending; → LINE if image lines remain, else → PAD. Edge and decrement in same cycle: pending unchanged.
- LINE: `IMG_W` contiguous reads, then → WAIT_REQ.
- PAD: `IMG_W` beats with `o_data_valid`=1, `o_data`=0, `o_rd_en`=0; then → WAIT_REQ until `PAD_LINES` sent, then → DONE.
- DONE: `o_done`=1 for one cycle, `o_busy` drops, → IDLE. Pending discarded.
- `i_start` while not IDLE: ignored, no effect on counters.
- `o_data` when `o_data_valid`=0: holds last value.

## Timing
- Reset (async assert, any state): state IDLE; `o_rd_en`, `o_data_valid`, `o_busy`, `o_done` = 0; `o_rd_addr`, `o_data` = 0; pending = 0. Mid-stream reset aborts immediately; no further beats.
- Start accepted at edge T: `o_busy`=1 and first `o_rd_en` at T+1; first `o_data_valid` at T+2 (memory latency 1, output register 0 extra: `o_data_valid` = registered `o_rd_en`, `o_data` = `i_rd_data`).
- Pad beats are aligned to the same 1-cycle pipeline: valid appears 1 cycle after the pad beat is issued.
- WAIT_REQ with pending>0 at cycle C: first `o_rd_en` at C+1. Minimum gap between consecutive lines: 1 idle cycle on `o_data_valid`.
- Request edge at cycle E in WAIT_REQ with pending=0: pending visible at E+1, first read at E+2.
- `o_done` asserts 1 cycle after last pad `o_data_valid`.
- Total valid beats per run: `(IMG_H+PAD_LINES)*IMG_W`.

## Test plan
Bench params: `IMG_W`=8, `IMG_H`=6, `PREFILL_LINES`=4, `PAD_LINES`=2, `REQ_W`=2; memory holds value = address[7:0].
- Prefill: start at T → 32 contiguous valid beats T+2..T+33, data 0..31, then `o_data_valid` low with no requests indefinitely.
- Request-driven lines: one `i_line_req` pulse after prefill → 8 beats data 32..39 starting 2 cycles after edge; second pulse → 40..47.
- Queued/saturating: 5 req edges during prefill → pending saturates at 3; exactly 2 image lines + 1 pad line follow back-to-back (1-cycle gaps), then wait.
- Padding/done: remaining requests → 16 beats of 0, `o_done` single pulse 1 cycle after last, `o_busy` low, total valid count 64.
- Start while busy: `i_start` during LINE → no restart, address continues monotonically.
- Reset mid-LINE: deassert `axi_reset_n` at beat 3 of line 5 → all outputs 0 asynchronously; new start replays from address 0.
